// File: rtl/bram_uart_sender_if.sv
// Signal bundle between the image read-back sender and its surroundings:
// start/busy/done control, the BRAM read port and the serial line.
interface bram_uart_sender_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [23:0]           dout;
  logic                  tx;

  modport master (input start, dout, output en, addr, tx, busy, done);
  modport slave  (output start, dout, input en, addr, tx, busy, done);
endinterface

// File: rtl/bram_uart_sender.sv
// Reads NUM_PIXELS 24-bit pixels from a BRAM port and streams each as three
// 8N1 UART bytes (R, G, B), producing the same byte stream the loader accepts.
module bram_uart_sender #(
  parameter int CLK_FREQUENCY = 100_208_000,
  parameter int BAUD_RATE     = 115200,
  parameter int ADDR_WIDTH    = 18,
  parameter int NUM_PIXELS    = 262144,
  parameter int BRAM_LATENCY  = 2
) (
  input logic               clk,
  input logic               rst_n,
  bram_uart_sender_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WW = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [CW-1:0]         CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [WW-1:0]         WAIT_LAST = WW'(BRAM_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST  = ADDR_WIDTH'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FINISH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  en_q, en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [23:0]           pixel_q, pixel_d;
  logic [1:0]            byte_q, byte_d;
  logic [3:0]            bit_q, bit_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [7:0]            cur_byte;

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = pixel_q[23:16];
      2'd1:    cur_byte = pixel_q[15:8];
      default: cur_byte = pixel_q[7:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    pixel_d   = pixel_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    clk_cnt_d = clk_cnt_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = READ;
        idx_d   = '0;
      end
      READ: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: if (wait_q == WAIT_LAST) begin
        // dout is valid now; the start bit goes out on the next cycle
        pixel_d   = bus.dout;
        byte_d    = 2'd0;
        bit_d     = 4'd0;
        clk_cnt_d = '0;
        tx_d      = 1'b0;
        state_d   = SEND;
      end else begin
        wait_d = wait_q + WW'(1);
      end
      SEND: if (clk_cnt_q != CLK_LAST) begin
        clk_cnt_d = clk_cnt_q + CW'(1);
      end else begin
        clk_cnt_d = '0;
        if (bit_q == 4'd9) begin
          if (byte_q == 2'd2) begin
            if (idx_q == PIX_LAST) begin
              state_d = FINISH;
            end else begin
              idx_d   = idx_q + ADDR_WIDTH'(1);
              state_d = READ;
            end
          end else begin
            byte_d = byte_q + 2'd1;
            bit_d  = 4'd0;
            tx_d   = 1'b0;
          end
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port outputs are registered copies of what the next state implies
  always_comb begin
    en_d   = (state_d == READ);
    addr_d = (state_d == READ) ? idx_d : addr_q;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pixel_q   <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      clk_cnt_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pixel_q   <= pixel_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      clk_cnt_q <= clk_cnt_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.en   = en_q;
  assign bus.addr = addr_q;
  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_bram_uart_sender.sv
// Bench for bram_uart_sender: BRAM model, UART frame monitor fed by an
// expected-byte queue, and directed transfers with hand-computed timing.
module tb_bram_uart_sender;
  localparam int CPB = 10;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0]  exp_q[$];
  logic [23:0] mem [0:3];
  logic [23:0] r1, r2;

  bram_uart_sender_if #(.ADDR_WIDTH(18)) bus ();

  bram_uart_sender #(
    .CLK_FREQUENCY(1000),
    .BAUD_RATE    (100),
    .ADDR_WIDTH   (18),
    .NUM_PIXELS   (2),
    .BRAM_LATENCY (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle read latency BRAM
  always @(posedge clk) begin
    if (bus.en) r1 <= mem[bus.addr[1:0]];
    r2 <= r1;
  end
  assign bus.dout = r2;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // UART monitor: every tx low outside a frame starts a frame, checked
  // sample-by-sample against the next expected byte.
  logic [7:0] m_exp, m_got;
  logic [9:0] m_fr;
  int         m_badn;
  bit         m_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_frame: tx low at cycle %0d, want no frame", cyc);
          m_exp = 8'h00;
        end else begin
          m_exp = exp_q.pop_front();
        end
        m_fr    = {1'b1, m_exp, 1'b0};
        m_badn  = 0;
        m_abort = 1'b0;
        m_got   = 8'h00;
        for (int j = 0; j < 10*CPB; j++) begin
          if (j > 0) @(negedge clk);
          if (!rst_n) begin
            m_abort = 1'b1;
            break;
          end
          if (bus.tx !== m_fr[j/CPB]) m_badn++;
          if (j % CPB == CPB/2 && j/CPB >= 1 && j/CPB <= 8) m_got[j/CPB-1] = bus.tx;
        end
        if (!m_abort) begin
          n_cmp++;
          if (m_badn != 0 || m_got !== m_exp) begin
            n_bad++;
            $display("FAIL frame: got byte %h (%0d bad samples), want byte %h", m_got, m_badn, m_exp);
          end
        end
      end
    end
  end

  // Runs one transfer starting in the current cycle; returns one cycle after done.
  task automatic run_xfer(input logic [23:0] p0, input logic [23:0] p1, input int ign_at);
    int t0, rel;
    int en1_c, en1_a, en2_c, en2_a, en_extra, tx_c, done_c, done_n;
    int busy1, busy607, busy608;
    en1_c = -1; en1_a = -1; en2_c = -1; en2_a = -1; en_extra = 0;
    tx_c = -1; done_c = -1; done_n = 0; busy1 = -1; busy607 = -1; busy608 = -1;
    exp_q.push_back(p0[23:16]); exp_q.push_back(p0[15:8]); exp_q.push_back(p0[7:0]);
    exp_q.push_back(p1[23:16]); exp_q.push_back(p1[15:8]); exp_q.push_back(p1[7:0]);
    bus.start = 1'b1;
    t0 = cyc;
    for (int r = 1; r <= 700; r++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (bus.en) begin
        if (en1_c < 0) begin en1_c = rel; en1_a = int'(bus.addr); end
        else if (en2_c < 0) begin en2_c = rel; en2_a = int'(bus.addr); end
        else en_extra++;
      end
      if (bus.tx === 1'b0 && tx_c < 0) tx_c = rel;
      if (bus.done) begin
        done_n++;
        if (done_c < 0) done_c = rel;
      end
      if (rel == 1)   busy1   = int'(bus.busy);
      if (rel == 607) busy607 = int'(bus.busy);
      if (rel == 608) busy608 = int'(bus.busy);
      bus.start = (rel == ign_at);
      if (rel == 608) break;
    end
    chk("en0_cycle", en1_c, 1);
    chk("en0_addr", en1_a, 0);
    chk("tx_fall_cycle", tx_c, 4);
    chk("en1_cycle", en2_c, 304);
    chk("en1_addr", en2_a, 1);
    chk("en_extra", en_extra, 0);
    chk("done_cycle", done_c, 607);
    chk("done_count", done_n, 1);
    chk("busy_after_start", busy1, 1);
    chk("busy_at_done", busy607, 1);
    chk("busy_after_done", busy608, 0);
  endtask

  int viol;
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 24'h0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(bus.tx), 1);
    chk("rst_en", int'(bus.en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_addr", int'(bus.addr), 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of the first frame (data bit 3 of A5, tx low)
    mem[0] = 24'hA53C0F;
    mem[1] = 24'h00FF81;
    exp_q.push_back(8'hA5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_rst_tx", int'(bus.tx), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(bus.tx), 1);
    chk("midrst_en", int'(bus.en), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) viol++;
    end
    chk("quiet_after_rst", viol, 0);

    // Plain transfer, then one with a start during byte 2, then back-to-back
    run_xfer(24'hA53C0F, 24'h00FF81, -1);
    run_xfer(24'hA53C0F, 24'h00FF81, 150);
    run_xfer(24'hA53C0F, 24'h00FF81, -1);

    // Edge data; start pulsed in the done cycle must be ignored
    mem[0] = 24'h000000;
    mem[1] = 24'hFFFFFF;
    run_xfer(24'h000000, 24'hFFFFFF, 607);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.en !== 1'b0 || bus.tx !== 1'b1) viol++;
    end
    chk("idle_after_done_start", viol, 0);
    chk("queue_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
